// File: rtl/bus_master.sv
// rtl/bus_master.sv - SPI-to-system-bus master issuing slotted RAM cycles
// Optional feature macro: CPU_CLK_EN (share each 16-clock bus cycle with a CPU phase-2 clock)
module bus_master (
   input  logic        clk_sys_i,
   input  logic        reset_ni,
   input  logic        spi_valid_i,
   input  logic [16:0] spi_addr_i,
   input  logic [7:0]  spi_data_i,
   input  logic        spi_rw_ni,
   output logic        spi_ready_o,
   output logic [7:0]  spi_data_o,
   input  logic [7:0]  bus_data_i,
   output logic [16:0] bus_addr_o,
   output logic        bus_addr_oe,
   output logic [7:0]  bus_data_o,
   output logic        bus_data_oe,
   output logic        bus_rw_no,
   output logic        bus_rw_noe,
   output logic        ram_ce_o,
   output logic        ram_oe_o,
   output logic        ram_we_o,
   output logic        cpu_clk_o,
   output logic        cpu_be_o,
   output logic        overrun_o
);

   typedef enum logic [1:0] {S_IDLE, S_PEND, S_ACTIVE} state_t;

`ifdef CPU_CLK_EN
   localparam logic CPU_BE_IDLE = 1'b1;
`else
   localparam logic CPU_BE_IDLE = 1'b0;
`endif

   state_t      r_state;
   logic [3:0]  r_cyc;
   logic [16:0] r_addr;
   logic [7:0]  r_data;
   logic        r_rw;
   logic [7:0]  r_rdata;
   logic        r_ready;
   logic        r_addr_oe;
   logic        r_data_oe;
   logic        r_rw_oe;
   logic        r_ce;
   logic        r_oe;
   logic        r_we;
   logic        r_cpu_clk;
   logic        r_cpu_be;
   logic        r_overrun;

   logic [3:0]  w_cyc_inc;
   logic        w_busy;

   assign w_cyc_inc = r_cyc + 4'd1;
   assign w_busy    = (r_state != S_IDLE);

   // Strobes are decoded one clock ahead from r_cyc so each registered
   // output lines up with the cyc value of the cycle it belongs to.
   always_ff @(posedge clk_sys_i) begin
      if (!reset_ni) begin
         r_state   <= S_IDLE;
         r_cyc     <= 4'd0;
         r_addr    <= 17'd0;
         r_data    <= 8'd0;
         r_rw      <= 1'b0;
         r_rdata   <= 8'd0;
         r_ready   <= 1'b0;
         r_addr_oe <= 1'b0;
         r_data_oe <= 1'b0;
         r_rw_oe   <= 1'b0;
         r_ce      <= 1'b0;
         r_oe      <= 1'b0;
         r_we      <= 1'b0;
         r_cpu_clk <= 1'b0;
         r_cpu_be  <= CPU_BE_IDLE;
         r_overrun <= 1'b0;
      end else begin
         r_cyc     <= w_cyc_inc;
         r_ready   <= 1'b0;
         r_addr_oe <= 1'b0;
         r_data_oe <= 1'b0;
         r_rw_oe   <= 1'b0;
         r_ce      <= 1'b0;
         r_oe      <= 1'b0;
         r_we      <= 1'b0;
         r_cpu_be  <= CPU_BE_IDLE;
`ifdef CPU_CLK_EN
         r_cpu_clk <= w_cyc_inc[3];
`else
         r_cpu_clk <= 1'b0;
`endif
         if (spi_valid_i && w_busy) begin
            r_overrun <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (spi_valid_i) begin
                  r_addr <= spi_addr_i;
                  r_data <= spi_data_i;
                  r_rw   <= spi_rw_ni;
`ifdef CPU_CLK_EN
                  if (r_cyc == 4'd15) begin
                     r_state  <= S_ACTIVE;
                     r_cpu_be <= 1'b0;
                  end else begin
                     r_state <= S_PEND;
                  end
`else
                  // Without the CPU there is no phase to wait for: restart the slot counter.
                  r_cyc   <= 4'd0;
                  r_state <= S_ACTIVE;
`endif
               end
            end

            S_PEND: begin
               if (r_cyc == 4'd15) begin
                  r_state  <= S_ACTIVE;
                  r_cpu_be <= 1'b0;
               end
            end

            S_ACTIVE: begin
               if (r_cyc == 4'd7) begin
                  r_state <= S_IDLE;
               end else begin
                  r_cpu_be  <= 1'b0;
                  r_addr_oe <= (r_cyc <= 4'd5);
                  r_rw_oe   <= (r_cyc <= 4'd5);
                  r_ce      <= (r_cyc <= 4'd5);
                  r_oe      <= r_rw && (r_cyc >= 4'd1) && (r_cyc <= 4'd5);
                  r_data_oe <= !r_rw && (r_cyc >= 4'd1) && (r_cyc <= 4'd5);
                  r_we      <= !r_rw && (r_cyc >= 4'd2) && (r_cyc <= 4'd4);
                  r_ready   <= (r_cyc == 4'd6);
               end
               if (r_rw && (r_cyc == 4'd6)) begin
                  r_rdata <= bus_data_i;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign spi_ready_o = r_ready;
   assign spi_data_o  = r_rdata;
   assign bus_addr_o  = r_addr;
   assign bus_addr_oe = r_addr_oe;
   assign bus_data_o  = r_data;
   assign bus_data_oe = r_data_oe;
   assign bus_rw_no   = r_rw;
   assign bus_rw_noe  = r_rw_oe;
   assign ram_ce_o    = r_ce;
   assign ram_oe_o    = r_oe;
   assign ram_we_o    = r_we;
   assign cpu_clk_o   = r_cpu_clk;
   assign cpu_be_o    = r_cpu_be;
   assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_bus_master.sv
// tb/tb_bus_master.sv - self-checking bench for bus_master (either CPU_CLK_EN build)
module tb_bus_master;
`ifdef CPU_CLK_EN
   localparam logic CPU = 1'b1;
`else
   localparam logic CPU = 1'b0;
`endif

   logic        clk_sys_i = 1'b0;
   logic        reset_ni = 1'b0;
   logic        spi_valid_i = 1'b0;
   logic [16:0] spi_addr_i = '0;
   logic [7:0]  spi_data_i = '0;
   logic        spi_rw_ni = 1'b0;
   logic [7:0]  bus_data_i = '0;
   logic        spi_ready_o;
   logic [7:0]  spi_data_o;
   logic [16:0] bus_addr_o;
   logic        bus_addr_oe;
   logic [7:0]  bus_data_o;
   logic        bus_data_oe;
   logic        bus_rw_no;
   logic        bus_rw_noe;
   logic        ram_ce_o;
   logic        ram_oe_o;
   logic        ram_we_o;
   logic        cpu_clk_o;
   logic        cpu_be_o;
   logic        overrun_o;

   bus_master dut (
      .clk_sys_i(clk_sys_i), .reset_ni(reset_ni),
      .spi_valid_i(spi_valid_i), .spi_addr_i(spi_addr_i), .spi_data_i(spi_data_i),
      .spi_rw_ni(spi_rw_ni), .spi_ready_o(spi_ready_o), .spi_data_o(spi_data_o),
      .bus_data_i(bus_data_i), .bus_addr_o(bus_addr_o), .bus_addr_oe(bus_addr_oe),
      .bus_data_o(bus_data_o), .bus_data_oe(bus_data_oe), .bus_rw_no(bus_rw_no),
      .bus_rw_noe(bus_rw_noe), .ram_ce_o(ram_ce_o), .ram_oe_o(ram_oe_o),
      .ram_we_o(ram_we_o), .cpu_clk_o(cpu_clk_o), .cpu_be_o(cpu_be_o),
      .overrun_o(overrun_o)
   );

   always #5 clk_sys_i = ~clk_sys_i;

   typedef struct {
      logic        rw;
      logic [16:0] addr;
      logic [7:0]  data;
      logic [7:0]  bus;
      int          cyc;
      int          lat;
      logic [7:0]  exp_rd;
   } vec_t;

   vec_t tv [5];
   int vectors = 0;
   int miscompares = 0;
   int pulses = 0;

   // Reference model: one transaction described by its strobe cycle and
   // the absolute cycle index at which its 8-cycle ACTIVE window begins.
   int          m_n = 0;
   int          m_s = 0;
   int          m_lat = 0;
   logic        m_has = 1'b0;
   int          m_cyc = 0;
   logic [16:0] m_addr = '0;
   logic [7:0]  m_data = '0;
   logic        m_rw = 1'b0;
   logic [7:0]  m_rdata = '0;
   logic        m_ovr = 1'b0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, m_n, got, exp);
      end
   endtask

   function automatic logic m_busy();
      return m_has && (m_n > m_lat) && (m_n <= m_s + 7);
   endfunction

   task automatic model_edge(input logic v, input logic [16:0] a, input logic [7:0] d,
                             input logic rw, input logic [7:0] bd, input logic rn);
      logic acc;
      if (!rn) begin
         m_cyc = 0; m_has = 1'b0; m_ovr = 1'b0;
         m_addr = '0; m_data = '0; m_rw = 1'b0; m_rdata = '0;
      end else begin
         if (v && m_busy()) m_ovr = 1'b1;
         if (m_has && m_rw && (m_n == m_s + 6)) m_rdata = bd;
         acc = v && !m_busy();
         if (acc) begin
            m_lat = m_n; m_has = 1'b1;
            m_addr = a; m_data = d; m_rw = rw;
            m_s = CPU ? (m_n + 16 - m_cyc) : (m_n + 1);
         end
         m_cyc = (acc && !CPU) ? 0 : (m_cyc + 1) % 16;
      end
      m_n++;
   endtask

   function automatic logic [63:0] exp_vec();
      int k;
      logic act, a16, rd26, wr26, wr35;
      k = m_n - m_s;
      act = m_has && (k >= 0) && (k <= 7);
      a16 = act && (k >= 1) && (k <= 6);
      rd26 = act && m_rw && (k >= 2) && (k <= 6);
      wr26 = act && !m_rw && (k >= 2) && (k <= 6);
      wr35 = act && !m_rw && (k >= 3) && (k <= 5);
      return {20'd0, act && (k == 7), m_rdata, m_addr, a16, m_data, wr26, m_rw, a16,
              a16, rd26, wr35, CPU && (m_cyc >= 8), CPU && !act, m_ovr};
   endfunction

   function automatic logic [63:0] dut_vec();
      return {20'd0, spi_ready_o, spi_data_o, bus_addr_o, bus_addr_oe, bus_data_o, bus_data_oe,
              bus_rw_no, bus_rw_noe, ram_ce_o, ram_oe_o, ram_we_o, cpu_clk_o, cpu_be_o, overrun_o};
   endfunction

   task automatic step(input logic v, input logic [16:0] a, input logic [7:0] d,
                       input logic rw, input logic [7:0] bd, input logic rn);
      spi_valid_i = v; spi_addr_i = a; spi_data_i = d; spi_rw_ni = rw;
      bus_data_i = bd; reset_ni = rn;
      @(posedge clk_sys_i);
      #1;
      model_edge(v, a, d, rw, bd, rn);
      if (spi_ready_o) pulses++;
      check("cycle", dut_vec(), exp_vec());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 8'($urandom), 1'b1);
   endtask

   task automatic idle_until_free();
      for (int i = 0; i < 40 && m_busy(); i++) idle(1);
   endtask

   task automatic wait_active_k(input int k);
      for (int i = 0; i < 40 && !(m_has && (m_n - m_s == k)); i++) idle(1);
      check("reach_slot", m_has && (m_n - m_s == k), 1);
   endtask

   initial begin
      int lat, p0, n_clk, n_be;

      tv[0] = '{1'b1, 17'h08000, 8'h00, 8'h5A, 15, 8, 8'h5A};
      tv[1] = '{1'b0, 17'h1FFFF, 8'hA5, 8'h33, 0,  8, 8'h5A};
      tv[2] = '{1'b1, 17'h00000, 8'h00, 8'hFF, 7,  8, 8'hFF};
      tv[3] = '{1'b0, 17'h12345, 8'h3C, 8'h00, 8,  8, 8'hFF};
      tv[4] = '{1'b1, 17'h1ABCD, 8'h00, 8'h00, 3,  8, 8'h00};
`ifdef CPU_CLK_EN
      tv[1].lat = 23; tv[2].lat = 16; tv[3].lat = 15; tv[4].lat = 20;
`endif

      for (int i = 0; i < 3; i++) step(1'b1, 17'h1FFFF, 8'hFF, 1'b1, 8'hFF, 1'b0);
      check("reset_vec", dut_vec(), {20'd0, 42'd0, CPU, 1'b0});

      for (int i = 0; i < 5; i++) begin
         idle_until_free();
         for (int w = 0; w < 17 && m_cyc != tv[i].cyc; w++)
            step(1'b0, '0, '0, 1'b0, tv[i].bus, 1'b1);
         step(1'b1, tv[i].addr, tv[i].data, tv[i].rw, tv[i].bus, 1'b1);
         lat = 1;
         while (!spi_ready_o && lat < 40) begin
            step(1'b0, '0, '0, 1'b0, tv[i].bus, 1'b1);
            lat++;
         end
         check("latency", lat, tv[i].lat);
         check("spi_data", spi_data_o, tv[i].exp_rd);
         check("bus_addr", bus_addr_o, tv[i].addr);
         check("bus_data", bus_data_o, tv[i].data);
      end

      // Second strobe mid-ACTIVE: dropped, sticky overrun, single ready.
      idle_until_free();
      step(1'b0, '0, '0, 1'b0, '0, 1'b0);
      idle(1);
      step(1'b1, 17'h0ABCD, 8'h11, 1'b0, '0, 1'b1);
      wait_active_k(2);
      check("no_overrun_yet", overrun_o, 0);
      p0 = pulses;
      step(1'b1, 17'h15555, 8'hEE, 1'b1, '0, 1'b1);
      check("overrun", overrun_o, 1);
      idle(30);
      check("one_ready", pulses - p0, 1);
      check("addr_kept", bus_addr_o, 17'h0ABCD);
      check("data_kept", bus_data_o, 8'h11);
      check("rw_kept", bus_rw_no, 0);

      // Reset at ACTIVE cyc 4 of a write aborts it.
      step(1'b1, 17'h00F0F, 8'h77, 1'b0, '0, 1'b1);
      wait_active_k(4);
      check("we_before", ram_we_o, 1);
      p0 = pulses;
      step(1'b0, '0, '0, 1'b0, '0, 1'b0);
      check("we_drop", ram_we_o, 0);
      check("abort_vec", dut_vec(), {20'd0, 42'd0, CPU, 1'b0});
      idle(20);
      check("no_ready", pulses - p0, 0);

      // Strobe at the ACTIVE->IDLE boundary is still busy.
      step(1'b1, 17'h00123, 8'h00, 1'b1, 8'h9C, 1'b1);
      wait_active_k(7);
      step(1'b1, 17'h00456, 8'h00, 1'b1, 8'h9C, 1'b1);
      check("overrun_cyc7", overrun_o, 1);
      check("addr_cyc7", bus_addr_o, 17'h00123);

      idle_until_free();
      n_clk = 0; n_be = 0;
      for (int i = 0; i < 64; i++) begin
         idle(1);
         n_clk += int'(cpu_clk_o);
         n_be += int'(cpu_be_o);
      end
`ifdef CPU_CLK_EN
      check("cpu_clk_high", n_clk, 32);
      check("cpu_be_high", n_be, 64);
`else
      check("cpu_clk_high", n_clk, 0);
      check("cpu_be_high", n_be, 0);
`endif

      for (int i = 0; i < 800; i++)
         step(($urandom % 6) == 0, 17'($urandom), 8'($urandom), 1'($urandom),
              8'($urandom), ($urandom % 150) != 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
